// File: rtl/fetch_queue.sv
// ============================================================================
// fetch_queue : instruction fetch issue plus decode-side prefetch queue
// Optional macro FETCH_QUEUE_BYPASS_EN: empty-queue response forwarded to decode
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fetch_queue #(
  parameter int              PC_W     = 16,
  parameter int              ADDR_W   = 14,
  parameter int              DATA_W   = 16,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect_en,
  input  logic [PC_W-1:0]            redirect_pc,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       id_ready,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [PC_W-1:0]            fetch_npc,
  output logic                       if_valid,
  output logic [DATA_W-1:0]          if_instr,
  output logic [PC_W-1:0]            if_npc,
  output logic [$clog2(DEPTH):0]     fill_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]   fetch_pc_q;
  logic              inflight_q;
  logic [PC_W-1:0]   infl_npc_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [PC_W-1:0]   npc_q   [DEPTH];

  logic resp_valid, wr_en, rd_en, pop;

  // A response that lands during a redirect belongs to the old path.
  assign resp_valid = inflight_q & ~redirect_en;
  assign mem_req    = ~reset & ~redirect_en &
                      (({1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q}) < (CNT_W+1)'(DEPTH));
  assign mem_addr   = fetch_pc_q[ADDR_W-1:0];
  assign fetch_npc  = fetch_pc_q + PC_W'(1);
  assign fill_level = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic byp;
  always_comb begin
    byp      = resp_valid & (count_q == '0);
    if_valid = (count_q != '0) | byp;
    if_instr = byp ? mem_rdata  : instr_q[rd_ptr_q];
    if_npc   = byp ? infl_npc_q : npc_q[rd_ptr_q];
    pop      = if_valid & id_ready & ~redirect_en;
    wr_en    = resp_valid & ~(byp & id_ready);
    rd_en    = pop & ~byp;
  end
`else
  always_comb begin
    if_valid = (count_q != '0);
    if_instr = instr_q[rd_ptr_q];
    if_npc   = npc_q[rd_ptr_q];
    pop      = if_valid & id_ready & ~redirect_en;
    wr_en    = resp_valid;
    rd_en    = pop;
  end
`endif

  always_comb begin
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      infl_npc_q <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        npc_q[i]   <= '0;
      end
    end else if (redirect_en) begin
      fetch_pc_q <= redirect_pc;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      inflight_q <= mem_req;
      if (mem_req) begin
        fetch_pc_q <= fetch_npc;
        infl_npc_q <= fetch_npc;
      end
      if (wr_en) begin
        instr_q[wr_ptr_q] <= mem_rdata;
        npc_q[wr_ptr_q]   <= infl_npc_q;
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      end
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && !redirect_en)
      assert (!(wr_en && count_q == CNT_W'(DEPTH)))
        else $error("fetch_queue: push into full queue");
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// tb_fetch_queue : scoreboard bench for fetch_queue (default parameters)
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_queue;

  localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset, redirect_en, id_ready;
  logic [15:0] redirect_pc, mem_rdata;
  logic        mem_req, if_valid;
  logic [13:0] mem_addr;
  logic [15:0] fetch_npc, if_instr, if_npc;
  logic [2:0]  fill_level;

  fetch_queue dut (
    .clk         (clk),
    .reset       (reset),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .mem_rdata   (mem_rdata),
    .id_ready    (id_ready),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .fetch_npc   (fetch_npc),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_npc      (if_npc),
    .fill_level  (fill_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] npc;
    int          fcyc;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0, n_err = 0, cyc = 0, req_cnt = 0;
  logic [15:0] model_pc = 16'h0;
  bit          after_rst = 1'b0, live = 1'b0;

  function automatic logic [15:0] img(input logic [15:0] pc);
    return pc ^ 16'h5A3C ^ {pc[7:0], pc[15:8]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive inputs, check at negedge against the model, then advance.
  task automatic tick(input bit rst, input bit red, input logic [15:0] rpc, input bit rdy);
    bit          req_now, vexp, issued;
    int          fill;
    logic [15:0] pc_issued, npc_exp;
    reset = rst; redirect_en = red; redirect_pc = rpc; id_ready = rdy;
    vexp = 1'b0; issued = 1'b0; pc_issued = model_pc;
    npc_exp = model_pc + 16'd1;
    req_now = !rst && !red && (sb.size() < DEPTH);
    @(negedge clk);
    if (mem_req) req_cnt++;
    if (live) begin
      chk("mem_req", {31'b0, mem_req}, {31'b0, req_now});
      if (!rst) begin
        if (req_now) begin
          chk("mem_addr", {18'b0, mem_addr}, {18'b0, model_pc[13:0]});
          chk("fetch_npc", {16'b0, fetch_npc}, {16'b0, npc_exp});
        end
        vexp = (sb.size() > 0) &&
               ((sb[0].fcyc + 2 <= cyc) || (LAT == 1 && sb[0].fcyc + 1 == cyc && !red));
        chk("if_valid", {31'b0, if_valid}, {31'b0, vexp});
        if (vexp) begin
          chk("if_instr", {16'b0, if_instr}, {16'b0, sb[0].instr});
          chk("if_npc", {16'b0, if_npc}, {16'b0, sb[0].npc});
        end else if (after_rst) begin
          chk("if_instr_rst", {16'b0, if_instr}, 32'h0);
          chk("if_npc_rst", {16'b0, if_npc}, 32'h0);
        end
        fill = 0;
        foreach (sb[i]) if (sb[i].fcyc + 2 <= cyc) fill++;
        chk("fill_level", {29'b0, fill_level}, fill);
      end
    end
    if (rst) begin
      sb.delete();
      model_pc = 16'h0;
    end else if (red) begin
      sb.delete();
      model_pc = rpc;
    end else begin
      if (vexp && rdy) void'(sb.pop_front());
      if (req_now) begin
        sb.push_back('{img(model_pc), npc_exp, cyc});
        model_pc = npc_exp;
        issued = 1'b1;
      end
    end
    after_rst = rst;
    @(posedge clk);
    #1;
    mem_rdata = issued ? img(pc_issued) : 16'hDEAD;
    cyc++;
    live = 1'b1;
  endtask

  initial begin
    reset = 1'b1; redirect_en = 1'b0; redirect_pc = '0; id_ready = 1'b0; mem_rdata = 16'hDEAD;
    repeat (3) tick(1, 0, 16'h0, 1);
    // Streaming fetch from RESET_PC with decode always ready
    repeat (12) tick(0, 0, 16'h0, 1);

    // Stall decode from an empty queue: exactly DEPTH fetches then saturation
    tick(0, 1, 16'h0040, 0);
    req_cnt = 0;
    repeat (10) tick(0, 0, 16'h0, 0);
    chk("req_pulses", req_cnt, 4);
    chk("fill_sat", {29'b0, fill_level}, 32'd4);
    repeat (8) tick(0, 0, 16'h0, 1);

    // Three queued plus one inflight, then redirect squashes everything
    repeat (6) tick(0, 0, 16'h0, 0);
    tick(0, 0, 16'h0, 1);
    tick(0, 0, 16'h0, 0);
    tick(0, 1, 16'h0100, 0);
    chk("redir_fill", {29'b0, fill_level}, 32'd0);
    chk("redir_addr", {18'b0, mem_addr}, 32'h100);
    repeat (8) tick(0, 0, 16'h0, 1);

    // Held redirect takes the last target
    tick(0, 1, 16'h0200, 1);
    tick(0, 1, 16'h0300, 1);
    repeat (5) tick(0, 0, 16'h0, 1);

    // PC wrap at the top of the address space
    tick(0, 1, 16'hFFFD, 1);
    repeat (8) tick(0, 0, 16'h0, 1);

    // Reset mid-stream with a full queue, and reset overriding redirect
    repeat (8) tick(0, 0, 16'h0, 0);
    tick(1, 0, 16'h0, 0);
    repeat (6) tick(0, 0, 16'h0, 1);
    tick(1, 1, 16'h1234, 1);
    repeat (6) tick(0, 0, 16'h0, 1);

    // Randomised decode back-pressure with occasional redirects
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 15) == 0)
        tick(0, 1, 16'($urandom), $urandom_range(0, 1) == 1);
      else
        tick(0, 0, 16'h0, $urandom_range(0, 2) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
